// File: rtl/axi_lite_regs_pkg.sv
// Shared constants for the AXI4-Lite register block: bus widths, response codes
// and the read-data pattern returned for unmapped addresses.
package axi_lite_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [DATA_W-1:0] INVALID_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// REG_NUM x 32-bit register storage with a byte-strobed write port, a combinational
// read mux and address-range decode for both ports.
module axi_lite_reg_bank
    import axi_lite_regs_pkg::*;
#(
    parameter int unsigned REG_NUM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [STRB_W-1:0] i_wr_strb,
    output logic              o_wr_addr_valid,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_addr_valid
);

    localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(REG_NUM * 4);

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;

    assign w_wr_idx        = i_wr_addr[2 +: IDX_W];
    assign w_rd_idx        = i_rd_addr[2 +: IDX_W];
    // Full-width compare so that upper address bits never alias into the bank.
    assign o_wr_addr_valid = (i_wr_addr < ADDR_LIMIT);
    assign o_rd_addr_valid = (i_rd_addr < ADDR_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && o_wr_addr_valid) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                if (w_wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (i_wr_strb[b]) begin
                            r_regs[i][8*b +: 8] <= i_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < int'(REG_NUM); i++) begin
            if (w_rd_idx == IDX_W'(i)) begin
                o_rd_data = r_regs[i];
            end
        end
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave front end: AW/W/AR/R/B handshakes around an axi_lite_reg_bank.
// One write and one read may be outstanding; the two paths are independent.
module axi_lite_slave_regs
    import axi_lite_regs_pkg::*;
#(
    parameter int unsigned REG_NUM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready
);

    logic              r_aw_held;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_w_held;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_wr_fire;
    logic              w_wr_addr_valid;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_addr_valid;

    // Readies depend on held state only, never on the incoming valids.
    assign awready   = !r_aw_held;
    assign wready    = !r_w_held;
    assign arready   = !r_rvalid;
    assign w_wr_fire = r_aw_held && r_w_held && !r_bvalid;

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;

    axi_lite_reg_bank #(
        .REG_NUM (REG_NUM)
    ) u_bank (
        .clk             (clk),
        .rst             (rst),
        .i_wr_en         (w_wr_fire),
        .i_wr_addr       (r_awaddr),
        .i_wr_data       (r_wdata),
        .i_wr_strb       (r_wstrb),
        .o_wr_addr_valid (w_wr_addr_valid),
        .i_rd_addr       (araddr),
        .o_rd_data       (w_rd_data),
        .o_rd_addr_valid (w_rd_addr_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (awvalid && !r_aw_held) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= awaddr;
            end
            if (wvalid && !r_w_held) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_addr_valid ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && bready) begin
                r_bvalid  <= 1'b0;
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
        end
    end

    // The bank mux reflects pre-update contents, so a read racing a write sees old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_addr_valid ? w_rd_data : INVALID_RDATA;
            r_rresp  <= w_rd_addr_valid ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: scoreboard queues hold expected
// B and R results, pushed at stimulus time and popped when the DUT responds.
module tb_axi_lite_slave_regs;
    import axi_lite_regs_pkg::*;

    localparam int NREG = 4;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_regs [NREG];
    logic [1:0]  wq [$];
    exp_t        rq [$];

    axi_lite_slave_regs #(.REG_NUM(NREG)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial forever #5 clk = ~clk;

    // Reference model of a write; returns the expected B response.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (a >= 32'(NREG * 4)) return RESP_SLVERR;
        idx = int'(a[3:2]);
        for (int b = 0; b < 4; b++) if (s[b]) exp_regs[idx][8*b +: 8] = d[8*b +: 8];
        return RESP_OKAY;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0;
        logic a_rdy, w_rdy;
        ok = 0; resp = 2'b11;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
            a_rdy = awready; w_rdy = wready;
            @(posedge clk); #1;
            if (awvalid && a_rdy) begin awvalid = 0; aw_done = 1; end
            if (wvalid && w_rdy) begin wvalid = 0; w_done = 1; end
        end
        awvalid = 0; wvalid = 0; bready = 1;
        for (int c = 0; c < 20; c++) begin
            if (bvalid) begin
                resp = bresp; ok = aw_done && w_done;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output bit ok);
        bit ar_done = 0;
        logic rdy;
        ok = 0; d = 'x; resp = 2'b11;
        araddr = a; arvalid = 1;
        for (int c = 0; c < 20 && !ar_done; c++) begin
            rdy = arready;
            @(posedge clk); #1;
            if (rdy) begin arvalid = 0; ar_done = 1; end
        end
        arvalid = 0; rready = 1;
        for (int c = 0; c < 20; c++) begin
            if (rvalid) begin
                d = rdata; resp = rresp; ok = ar_done;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e;
        rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fails++; $display("FAIL reset_readies: got %b expected 111", {awready, wready, arready});
        end
        n_checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_outputs: bv=%b rv=%b bresp=%b rresp=%b rdata=%h expected all 0",
                     bvalid, rvalid, bresp, rresp, rdata);
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        for (int i = 0; i < NREG; i++) begin
            rq.push_back('{RESP_OKAY, exp_regs[i]});
            do_read(32'(4 * i), d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL reset_read_%0d: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e; logic [1:0] eb;
        for (int i = 0; i < NREG; i++) begin
            wq.push_back(model_write(32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF));
            do_write(32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'hF, r, ok);
            eb = wq.pop_front(); n_checks++;
            if (!ok || r !== eb) begin
                n_fails++; $display("FAIL wr_bresp_%0d: got %b expected %b", i, r, eb);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            rq.push_back('{RESP_OKAY, 32'hA5A5_0000 + 32'(i)});
            do_read(32'(4 * i), d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL rd_back_%0d: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_invalid();
        logic [31:0] rd_addrs [6] = '{32'h20, 32'h10, 32'h8000_0004, 32'hC, 32'h5, 32'h3};
        logic [31:0] wr_addrs [2] = '{32'h20, 32'h8000_0000};
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e; logic [1:0] eb;
        for (int i = 0; i < 6; i++) begin
            if (rd_addrs[i] < 32'(NREG * 4)) rq.push_back('{RESP_OKAY, exp_regs[rd_addrs[i][3:2]]});
            else rq.push_back('{RESP_SLVERR, 32'hDEAD_BEEF});
            do_read(rd_addrs[i], d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL rd_decode_%h: got %h/%b expected %h/%b", rd_addrs[i], d, r, e.data, e.resp);
            end
        end
        for (int i = 0; i < 2; i++) begin
            wq.push_back(model_write(wr_addrs[i], 32'h1234_5678, 4'hF));
            do_write(wr_addrs[i], 32'h1234_5678, 4'hF, r, ok);
            eb = wq.pop_front(); n_checks++;
            if (!ok || r !== eb) begin
                n_fails++; $display("FAIL wr_invalid_%h: got %b expected %b", wr_addrs[i], r, eb);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            rq.push_back('{RESP_OKAY, 32'hA5A5_0000 + 32'(i)});
            do_read(32'(4 * i), d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL rd_after_bad_wr_%0d: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
            end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e; logic [1:0] eb;
        wq.push_back(model_write(32'h0, 32'h1122_3344, 4'b0101));
        do_write(32'h0, 32'h1122_3344, 4'b0101, r, ok);
        eb = wq.pop_front(); n_checks++;
        if (!ok || r !== eb) begin
            n_fails++; $display("FAIL strobe_bresp: got %b expected %b", r, eb);
        end
        rq.push_back('{RESP_OKAY, 32'hA522_0044});
        do_read(32'h0, d, r, ok);
        e = rq.pop_front(); n_checks++;
        if (!ok || d !== e.data || r !== e.resp) begin
            n_fails++; $display("FAIL strobe_read: got %h/%b expected %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] eb;
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1; wvalid = 0;
        wq.push_back(model_write(32'h8, 32'h0BAD_F00D, 4'hF));
        repeat (2) begin
            n_checks++;
            if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
                n_fails++; $display("FAIL w_first_hold: wready=%b bvalid=%b awready=%b expected 0 0 1", wready, bvalid, awready);
            end
            @(posedge clk); #1;
        end
        awaddr = 32'h8; awvalid = 1;
        @(posedge clk); #1; awvalid = 0;
        n_checks++;
        if (bvalid !== 1'b0 || awready !== 1'b0) begin
            n_fails++; $display("FAIL w_first_aw_edge: bvalid=%b awready=%b expected 0 0", bvalid, awready);
        end
        @(posedge clk); #1;
        eb = wq.pop_front(); n_checks++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            n_fails++; $display("FAIL w_first_b_latency: bvalid=%b bresp=%b expected 1 %b", bvalid, bresp, eb);
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fails++; $display("FAIL w_first_release: bv/awr/wr=%b expected 011", {bvalid, awready, wready});
        end
    endtask

    task automatic test_bready_stall();
        logic [1:0] eb;
        wq.push_back(model_write(32'hC, 32'h5566_7788, 4'hF));
        awaddr = 32'hC; wdata = 32'h5566_7788; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        @(posedge clk); #1;
        eb = wq.pop_front();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== eb || awready !== 1'b0 || wready !== 1'b0) begin
                n_fails++; $display("FAIL b_stall_%0d: bv=%b bresp=%b awr=%b wr=%b expected 1 %b 0 0", c, bvalid, bresp, awready, wready, eb);
            end
            @(posedge clk); #1;
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        n_checks++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fails++; $display("FAIL b_stall_release: bv/awr/wr=%b expected 011", {bvalid, awready, wready});
        end
    endtask

    task automatic test_rready_stall();
        exp_t e;
        rq.push_back('{RESP_OKAY, exp_regs[1]});
        araddr = 32'h4; arvalid = 1; rready = 0;
        @(posedge clk); #1; arvalid = 0;
        e = rq.pop_front();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp || arready !== 1'b0) begin
                n_fails++; $display("FAIL r_stall_%0d: rv=%b rdata=%h rresp=%b arr=%b expected 1 %h %b 0", c, rvalid, rdata, rresp, arready, e.data, e.resp);
            end
            araddr = 32'h0; arvalid = 1;  // must not be accepted while R is pending
            @(posedge clk); #1;
        end
        rq.push_back('{RESP_OKAY, exp_regs[0]});
        rready = 1; @(posedge clk); #1; rready = 0;
        n_checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== e.data) begin
            n_fails++; $display("FAIL r_stall_release: rv=%b arr=%b rdata=%h expected 0 1 %h", rvalid, arready, rdata, e.data);
        end
        @(posedge clk); #1; arvalid = 0;
        e = rq.pop_front(); n_checks++;
        if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
            n_fails++; $display("FAIL r_after_stall: rv=%b rdata=%h rresp=%b expected 1 %h %b", rvalid, rdata, rresp, e.data, e.resp);
        end
        rready = 1; @(posedge clk); #1; rready = 0;
    endtask

    task automatic test_same_edge();
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e; logic [1:0] eb;
        rq.push_back('{RESP_OKAY, exp_regs[1]});
        awaddr = 32'h4; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1; awvalid = 0; wvalid = 0;
        araddr = 32'h4; arvalid = 1;
        @(posedge clk); #1; arvalid = 0;
        wq.push_back(model_write(32'h4, 32'hCAFE_F00D, 4'hF));
        e = rq.pop_front(); n_checks++;
        if (rvalid !== 1'b1 || rdata !== e.data || rresp !== e.resp) begin
            n_fails++; $display("FAIL same_edge_old: rv=%b rdata=%h rresp=%b expected 1 %h %b", rvalid, rdata, rresp, e.data, e.resp);
        end
        eb = wq.pop_front(); n_checks++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            n_fails++; $display("FAIL same_edge_b: bvalid=%b bresp=%b expected 1 %b", bvalid, bresp, eb);
        end
        rready = 1; bready = 1; @(posedge clk); #1; rready = 0; bready = 0;
        rq.push_back('{RESP_OKAY, 32'hCAFE_F00D});
        do_read(32'h4, d, r, ok);
        e = rq.pop_front(); n_checks++;
        if (!ok || d !== e.data || r !== e.resp) begin
            n_fails++; $display("FAIL same_edge_new: got %h/%b expected %h/%b", d, r, e.data, e.resp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r; bit ok; exp_t e; logic [1:0] eb;
        awaddr = 32'h0; awvalid = 1;
        @(posedge clk); #1; awvalid = 0;
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b1) begin
            n_fails++; $display("FAIL mid_aw_held: awready=%b wready=%b expected 0 1", awready, wready);
        end
        #1 rst = 1; #1;
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_fails++; $display("FAIL mid_reset_state: awr/wr/arr/bv/rv=%b expected 11100", {awready, wready, arready, bvalid, rvalid});
        end
        @(posedge clk); @(negedge clk); rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        for (int i = 0; i < NREG; i++) begin
            rq.push_back('{RESP_OKAY, exp_regs[i]});
            do_read(32'(4 * i), d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL mid_reset_read_%0d: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
            end
        end
        // A lone W after reset must not complete against the aborted address.
        wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); #1; wvalid = 0;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fails++; $display("FAIL mid_stale_aw: bvalid=%b expected 0", bvalid);
        end
        wq.push_back(model_write(32'h8, 32'h7777_8888, 4'hF));
        awaddr = 32'h8; awvalid = 1;
        @(posedge clk); #1; awvalid = 0;
        bready = 1;
        @(posedge clk); #1;
        eb = wq.pop_front(); n_checks++;
        if (bvalid !== 1'b1 || bresp !== eb) begin
            n_fails++; $display("FAIL mid_after_write: bvalid=%b bresp=%b expected 1 %b", bvalid, bresp, eb);
        end
        @(posedge clk); #1; bready = 0;
        for (int i = 0; i < NREG; i++) begin
            rq.push_back('{RESP_OKAY, exp_regs[i]});
            do_read(32'(4 * i), d, r, ok);
            e = rq.pop_front(); n_checks++;
            if (!ok || d !== e.data || r !== e.resp) begin
                n_fails++; $display("FAIL mid_final_read_%0d: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_invalid();
        test_strobe();
        test_w_before_aw();
        test_bready_stall();
        test_rready_stall();
        test_same_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave exposing a bank of REG_NUM 32-bit read/write registers at word-aligned offsets 0x0, 0x4, and so on. It sits behind an AXI-Lite interconnect or master as a simple control/status register block. Reads of unmapped addresses return 32'hDEAD_BEEF with an error response.

Parameters:
REG_NUM, 4, number of 32-bit registers; must be at least 1. Address window is 0 to REG_NUM*4-1.

Ports:
clk  in  1  single clock; all logic is on its rising edge
rst  in  1  asynchronous, active-high reset
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte write strobes; bit i enables wdata[8i+7:8i]
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
rvalid  out  1  read data valid
rready  in  1  read data ready

Behaviour:
- Reset (asynchronous, while rst=1):
  - All registers are 0.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - AW, W and AR holding buffers are empty.
- Readies are combinational from internal state only, never from valid inputs:
  - awready = !aw_held
  - wready = !w_held
  - arready = !rvalid
  - All three are therefore 1 immediately after reset.
- Address decode:
  - Index = addr[2 +: max(1,$clog2(REG_NUM))]. addr[1:0] is ignored.
  - An address is valid iff addr < REG_NUM*4; all upper bits participate in the comparison.
- Write path:
  - AW and W channels are accepted independently, in either order or in the same cycle. A handshake is valid&&ready at a rising edge.
  - The accepted address or data is latched and its ready drops until the transaction completes.
  - In the first cycle with both aw_held and w_held set and bvalid=0, the write is performed.
    - Valid address: each byte with wstrb[i]=1 is updated; other bytes are kept; bresp=OKAY.
    - Invalid address: no register changes; bresp=SLVERR.
  - bvalid is asserted on the next edge. Latency is one cycle from the later of the AW/W handshakes to bvalid=1.
  - bvalid and bresp are held stable until bready=1 at a rising edge. That edge clears bvalid, aw_held and w_held, so awready and wready return to 1 in the following cycle.
  - There is at most one outstanding write.
- Read path:
  - AR handshake with arvalid=1 and arready=1 at a rising edge.
  - On the same edge, rdata/rresp are registered and rvalid is set to 1. Latency is one cycle.
    - Valid address: rdata = reg[index], rresp=OKAY.
    - Invalid address: rdata = 32'hDEAD_BEEF, rresp=SLVERR.
  - rdata, rresp and rvalid are held until rready=1 at a rising edge, which clears rvalid. rdata keeps its last value.
  - There is at most one outstanding read.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A read whose AR handshake occurs on the same edge as a register update returns the pre-update value.
  - bready or rready asserted before the corresponding valid is legal and has no effect.
- Reset mid-transaction aborts everything: buffers empty, valids low, registers 0.

Decomposition:
- Package axi_lite_regs_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - DATA_W=32, ADDR_W=32
  - INVALID_RDATA=32'hDEAD_BEEF
- One sub-module is natural: axi_lite_reg_bank. It contains REG_NUM×32 storage, the byte-strobed write port, the combinational read mux and the address-valid decode.
- Channel handshake logic stays in the top level.

Test Plan:
- Reset, then write offsets 0x0/0x4/0x8/0xC with 32'hA5A5_0000+i and wstrb=4'hF, then read them back -> bresp=OKAY each time; reads return A5A50000, A5A50001, A5A50002, A5A50003 with rresp=OKAY.
- Read 0x20 -> rdata=32'hDEAD_BEEF, rresp=2'b10. Write 0x20 with 32'h1234_5678 -> bresp=2'b10, and all four registers are unchanged on readback.
- reg0=32'hA5A5_0000, then write 0x0 with 32'h1122_3344 and wstrb=4'b0101 -> readback 32'hA522_0044.
- Back-pressure and ordering:
  - W presented 3 cycles before AW -> wready drops after the W handshake; bvalid rises one cycle after the AW handshake.
  - bready held 0 for 5 cycles -> bvalid and bresp stay stable; awready and wready stay 0 until the B handshake.
- rready held 0 for 4 cycles after a read of 0x4 -> rvalid and rdata stay stable; arready=0 until the R handshake. Same-edge read and write of 0x4 returns the old value.
- Assert rst mid-write, after AW is accepted but before W -> bvalid=0, readies=1, all registers read 0 after reset.
